uart_rx_byte: RTL

// - UART receiver feeding the byte-to-128-bit packer: deserialises an 8N1 RS-232 stream on one clock.
// - Presents each good byte on rx_data with a one-cycle rx_flag strobe, which the packer consumes directly.
// - Oversamples by counting: detects the start edge, checks mid-start, then samples each bit at its centre.
// - Flags framing errors and never emits a strobe for a bad frame.

---
 rtl/uart_rx_byte.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_byte.sv
// uart_rx_byte: 8N1 serial receiver; each good byte appears on rx_data with a one-cycle rx_flag.
// Latency: rx_flag rises one cycle after the stop-bit centre sample (start edge + HALF + 9*BAUD_DIV + 1).
// No backpressure: the consumer must take rx_data on the rx_flag cycle; bad frames raise frame_err only.
module uart_rx_byte #(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD_RATE = 115200
) (
    input  logic       sclk,
    input  logic       rst_n,
    input  logic       rs232_rx,
    output logic [7:0] rx_data,
    output logic       rx_flag,
    output logic       frame_err,
    output logic       rx_busy
);

    // Bit period and half period in sclk cycles.
    localparam int BAUD_DIV = CLK_FREQ / BAUD_RATE;
    localparam int HALF     = BAUD_DIV / 2;
    localparam int CNT_W    = $clog2(BAUD_DIV);

    localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(BAUD_DIV - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);

    // Receiver states.
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_START = 3'd1;
    localparam logic [2:0] ST_DATA  = 3'd2;
    localparam logic [2:0] ST_STOP  = 3'd3;
    localparam logic [2:0] ST_BREAK = 3'd4;

    logic             s1;
    logic             s2;
    logic             s3;
    logic [2:0]       hist_ok;
    logic             start_edge;

    logic [2:0]       state;
    logic [2:0]       next_state;
    logic [CNT_W-1:0] baud_cnt;
    logic [2:0]       bit_cnt;
    logic [7:0]       shift_reg;

    logic             half_tick;
    logic             bit_tick;
    logic             data_tick;
    logic             stop_tick;

    // Two-flop synchroniser plus a history flop for falling-edge detection.
    // hist_ok fills with ones as real line samples reach s1, s2 and s3; until
    // s3 holds a genuine sample, the reset value of s2 (high) must not be
    // mistaken for the line having been high, so a line held low across
    // reset release never looks like a start edge.
    always_ff @(posedge sclk) begin
        if (!rst_n) begin
            s1      <= 1'b1;
            s2      <= 1'b1;
            s3      <= 1'b0;
            hist_ok <= 3'b000;
        end else begin
            s1      <= rs232_rx;
            s2      <= s1;
            s3      <= s2;
            hist_ok <= {hist_ok[1:0], 1'b1};
        end
    end

    assign start_edge = hist_ok[2] & s3 & ~s2;

    // Sample points: mid start bit, then each bit centre one period apart.
    assign half_tick = (state == ST_START) && (baud_cnt == HALF_LAST);
    assign bit_tick  = (baud_cnt == DIV_LAST);
    assign data_tick = (state == ST_DATA) && bit_tick;
    assign stop_tick = (state == ST_STOP) && bit_tick;

    // Next-state decision for the frame walker.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (start_edge) begin
                    next_state = ST_START;
                end
            end
            ST_START: begin
                if (half_tick) begin
                    // Line back high at mid start bit: treat as a glitch.
                    next_state = s2 ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (data_tick && (bit_cnt == 3'd7)) begin
                    next_state = ST_STOP;
                end
            end
            ST_STOP: begin
                if (stop_tick) begin
                    next_state = s2 ? ST_IDLE : ST_BREAK;
                end
            end
            ST_BREAK: begin
                // Hold off until the line is released so a long break is one error.
                if (s2) begin
                    next_state = ST_IDLE;
                end
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge sclk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Baud counter: free-runs inside a bit period, restarts at every sample point.
    always_ff @(posedge sclk) begin
        if (!rst_n) begin
            baud_cnt <= '0;
        end else if ((state == ST_IDLE) || (state == ST_BREAK) ||
                     half_tick || data_tick || stop_tick) begin
            baud_cnt <= '0;
        end else begin
            baud_cnt <= baud_cnt + 1'b1;
        end
    end

    // Bit counter: index of the next data bit to be sampled.
    always_ff @(posedge sclk) begin
        if (!rst_n) begin
            bit_cnt <= 3'd0;
        end else if (state != ST_DATA) begin
            bit_cnt <= 3'd0;
        end else if (data_tick) begin
            bit_cnt <= bit_cnt + 3'd1;
        end
    end

    // Shift register: LSB arrives first, so shift right and insert at the top.
    always_ff @(posedge sclk) begin
        if (!rst_n) begin
            shift_reg <= 8'h00;
        end else if (data_tick) begin
            shift_reg <= {s2, shift_reg[7:1]};
        end
    end

    // Output strobes and the held byte, all decided at the stop-bit sample.
    always_ff @(posedge sclk) begin
        if (!rst_n) begin
            rx_data   <= 8'h00;
            rx_flag   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_flag   <= 1'b0;
            frame_err <= 1'b0;
            if (stop_tick) begin
                if (s2) begin
                    rx_data <= shift_reg;
                    rx_flag <= 1'b1;
                end else begin
                    frame_err <= 1'b1;
                end
            end
        end
    end

    assign rx_busy = (state != ST_IDLE);

    // A frame ends in exactly one outcome, and strobes are single-cycle.
    a_flag_err_excl: assert property (@(posedge sclk) disable iff (!rst_n)
        !(rx_flag && frame_err));
    a_flag_single: assert property (@(posedge sclk) disable iff (!rst_n)
        rx_flag |=> !rx_flag);
    a_err_single: assert property (@(posedge sclk) disable iff (!rst_n)
        frame_err |=> !frame_err);

endmodule
